writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of writeback queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port src0_valid  input  1  source 0 (ALU path) write request.
REQ-005 The block SHALL have port src0_addr  input  3  source 0 destination register.
REQ-006 The block SHALL have port src0_data  input  32  source 0 write data.
REQ-007 The block SHALL have port src0_ready  output  1  source 0 request accepted this cycle when high with src0_valid.
REQ-008 The block SHALL have ports src1_valid/src1_addr/src1_data/src1_ready, with the same widths and meanings, for source 1 (memory path).
REQ-009 The block SHALL have port rf_we  output  1  register-file write enable, registered.
REQ-010 The block SHALL have port rf_wa  output  3  register-file write address, registered.
REQ-011 The block SHALL have port rf_wd  output  32  register-file write data, registered.
REQ-012 The block SHALL have ports q_addr1, q_addr2  input  3  hazard query addresses (decode-stage read addresses).
REQ-013 The block SHALL have ports q_pending1, q_pending2  output  1  a write to the matching queried address is outstanding.
REQ-014 The block SHALL have port count  output  clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-015 Accepted requests SHALL enter a circular FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-016 src0_ready SHALL be high iff count < DEPTH and reset is low.
REQ-017 src1_ready SHALL be high iff (count + (src0_valid & src0_ready)) < DEPTH and reset is low; src0 has fixed priority.
REQ-018 When both sources are accepted in one cycle, the src0 entry SHALL occupy the lower queue position and be written first.
REQ-019 A request with addr = 3'b111 (PC alias, not writable) SHALL be accepted (ready per REQ-016/017) but SHALL NOT be enqueued or written.
REQ-020 On each rising edge with count > 0, the head entry SHALL be popped into rf_wa/rf_wd with rf_we = 1; with count = 0, rf_we SHALL be 0 and rf_wa/rf_wd SHALL hold their values.
REQ-021 Latency SHALL be: accepted at edge N, rf_we asserted after edge N+1 (earliest), one write per cycle, in strict FIFO order.
REQ-022 count SHALL update each edge as count + enqueues (0..2) - pop (0/1); simultaneous push and pop at count = DEPTH SHALL be legal (pop frees space only for the next cycle's ready).
REQ-023 Readiness SHALL NOT depend on same-cycle pop.
REQ-024 q_pendingN SHALL be 1 iff q_addrN != 3'b111 and it matches the address of any occupied queue entry or of the current rf_wa with rf_we = 1; combinational.
REQ-025 Back-to-back writes to the same address SHALL both be issued; no coalescing.

Reset
REQ-026 While reset is high at a rising edge: head = tail = 0, count = 0, rf_we = 0, rf_wa = 3'b000, rf_wd = 32'h0; requests presented during that cycle SHALL be discarded.
REQ-027 During reset, src0_ready = src1_ready = 0; q_pending1/2 = 0 from the cycle after reset.
REQ-028 Reset asserted mid-operation SHALL drop all queued entries without issuing them.

Verification
REQ-029 Single write: src0 {addr 3, data 32'hDEADBEEF} at edge N -> rf_we = 1, rf_wa = 3, rf_wd = DEADBEEF after edge N+1 only; q_pending for addr 3 is high from after N through the rf_we cycle.
REQ-030 Simultaneous: src0 {1, 32'h11}, src1 {2, 32'h22} in one cycle -> writes addr 1 then addr 2 on consecutive cycles; count goes 2 then 1 then 0.
REQ-031 Full: hold both sources valid with DEPTH = 4 -> count never exceeds 4; src1_ready = 0 whenever count = 3 and src0 is accepted; no entry is lost or reordered across pointer wrap (>= 12 writes).
REQ-032 PC alias: src1 {addr 7, data 32'hFFFF} -> src1_ready = 1, count unchanged, rf_we never asserted for addr 7, q_pending for addr 7 = 0.
REQ-033 Reset mid-burst: 3 entries queued, then reset for 1 cycle -> count = 0, rf_we = 0, and none of the 3 entries appears on rf_we after reset release.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter: src0/src1 requests share a circular queue that
// drains one register-file write per cycle in arrival order, with hazard lookup.
module writeback_query #(
  parameter int DEPTH = 4
) (
  input  logic [2:0]             q_addr,
  input  logic [DEPTH-1:0][2:0]  ent_addr,
  input  logic [DEPTH-1:0]       occ,
  input  logic                   rf_we,
  input  logic [2:0]             rf_wa,
  output logic                   pending
);
  always_comb begin
    pending = 1'b0;
    if (q_addr != 3'b111) begin
      if (rf_we && (rf_wa == q_addr)) pending = 1'b1;
      for (int i = 0; i < DEPTH; i++)
        if (occ[i] && (ent_addr[i] == q_addr)) pending = 1'b1;
    end
  end
endmodule

module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      src0_valid,
  input  logic [2:0]                src0_addr,
  input  logic [31:0]               src0_data,
  output logic                      src0_ready,
  input  logic                      src1_valid,
  input  logic [2:0]                src1_addr,
  input  logic [31:0]               src1_data,
  output logic                      src1_ready,
  output logic                      rf_we,
  output logic [2:0]                rf_wa,
  output logic [31:0]               rf_wd,
  input  logic [2:0]                q_addr1,
  input  logic [2:0]                q_addr2,
  output logic                      q_pending1,
  output logic                      q_pending2,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          NUM_Q    = 2;
  localparam logic [2:0]  PC_ALIAS = 3'b111;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0]      mem;
  logic [AW-1:0]            head, tail;
  logic                     acc0, acc1, en0, en1, pop;
  logic [DEPTH-1:0][2:0]    ent_addr;
  logic [DEPTH-1:0]         occ;
  logic [NUM_Q-1:0][2:0]    q_addr_v;
  logic [NUM_Q-1:0]         q_pend_v;

  // Readiness looks only at registered occupancy, never at this cycle's pop.
  assign src0_ready = !reset && (count < DEPTH_C);
  assign src1_ready = !reset && ((count + {{AW{1'b0}}, acc0}) < DEPTH_C);
  assign acc0 = src0_valid & src0_ready;
  assign acc1 = src1_valid & src1_ready;
  assign en0  = acc0 && (src0_addr != PC_ALIAS);
  assign en1  = acc1 && (src1_addr != PC_ALIAS);
  assign pop  = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= pop;
      if (pop) begin
        rf_wa <= mem[head].addr;
        rf_wd <= mem[head].data;
        head  <= head + AW'(1);
      end
      tail  <= tail + AW'(en0) + AW'(en1);
      count <= count + {{AW{1'b0}}, en0} + {{AW{1'b0}}, en1} - {{AW{1'b0}}, pop};
    end
  end

  // src0 takes the lower slot so it drains first.
  always_ff @(posedge clk) begin
    if (en0) mem[tail] <= '{addr: src0_addr, data: src0_data};
    if (en1) mem[tail + AW'(en0)] <= '{addr: src1_addr, data: src1_data};
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      assign ent_addr[i] = mem[i].addr;
      assign occ[i]      = ({1'b0, (AW'(i) - head)} < count);
    end
  endgenerate

  assign q_addr_v = {q_addr2, q_addr1};

  generate
    for (i = 0; i < NUM_Q; i++) begin : g_q
      writeback_query #(.DEPTH(DEPTH)) u_query (
        .q_addr   (q_addr_v[i]),
        .ent_addr (ent_addr),
        .occ      (occ),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .pending  (q_pend_v[i])
      );
    end
  endgenerate

  assign q_pending1 = q_pend_v[0];
  assign q_pending2 = q_pend_v[1];
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, corner sequences, and
// random traffic against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int NV    = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        src0_valid, src1_valid;
  logic [2:0]  src0_addr, src1_addr;
  logic [31:0] src0_data, src1_data;
  logic        src0_ready, src1_ready;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [2:0]  q_addr1, q_addr2;
  logic        q_pending1, q_pending2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data), .src1_ready(src1_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pending1(q_pending1), .q_pending2(q_pending2),
    .count(count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v0; logic [2:0] a0; logic [31:0] d0;
    logic v1; logic [2:0] a1; logic [31:0] d1;
    logic [2:0] q1; logic [2:0] q2;
    logic r0; logic r1; logic p1; logic p2;
    logic we; logic [2:0] wa; logic [31:0] wd; logic [2:0] cnt;
  } vec_t;
  vec_t tbl [NV];

  typedef struct { logic [2:0] a; logic [31:0] d; } ent_t;
  ent_t        mq [$];
  logic        m_we;
  logic [2:0]  m_wa;
  logic [31:0] m_wd;

  task automatic drive(input logic rst, input logic v0, input logic [2:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [31:0] d1,
                       input logic [2:0] qa1, input logic [2:0] qa2);
    reset = rst;
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
    q_addr1 = qa1; q_addr2 = qa2;
  endtask

  function automatic logic mpend(input logic [2:0] q);
    if (q == 3'b111) return 1'b0;
    if (m_we && (m_wa == q)) return 1'b1;
    foreach (mq[k]) if (mq[k].a == q) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus checked against the reference model.
  task automatic cyc(input logic rst, input logic v0, input logic [2:0] a0, input logic [31:0] d0,
                     input logic v1, input logic [2:0] a1, input logic [31:0] d1,
                     input logic [2:0] qa1, input logic [2:0] qa2);
    logic r0, r1;
    @(negedge clk);
    drive(rst, v0, a0, d0, v1, a1, d1, qa1, qa2);
    #1;
    r0 = !rst && (mq.size() < DEPTH);
    r1 = !rst && ((mq.size() + ((v0 && r0) ? 1 : 0)) < DEPTH);
    chk("m_src0_ready", 32'(src0_ready), 32'(r0));
    chk("m_src1_ready", 32'(src1_ready), 32'(r1));
    if (!rst) begin
      chk("m_q_pending1", 32'(q_pending1), 32'(mpend(qa1)));
      chk("m_q_pending2", 32'(q_pending2), 32'(mpend(qa2)));
    end
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (mq.size() > 0) begin
        m_we = 1'b1; m_wa = mq[0].a; m_wd = mq[0].d;
        void'(mq.pop_front());
      end else m_we = 1'b0;
      if (v0 && r0 && a0 != 3'b111) mq.push_back('{a0, d0});
      if (v1 && r1 && a1 != 3'b111) mq.push_back('{a1, d1});
    end
    @(posedge clk);
    #1;
    chk("m_rf_we", 32'(rf_we), 32'(m_we));
    chk("m_rf_wa", 32'(rf_wa), 32'(m_wa));
    chk("m_rf_wd", rf_wd, m_wd);
    chk("m_count", 32'(count), 32'(mq.size()));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0, 3'd3, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        3'd1};
    tbl[1]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd3, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 3'd0};
    tbl[2]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd3, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 32'hDEADBEEF, 3'd0};
    tbl[3]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'hDEADBEEF, 3'd0};
    tbl[4]  = '{1'b1, 3'd1, 32'h11,       1'b1, 3'd2, 32'h22, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'hDEADBEEF, 3'd2};
    tbl[5]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 32'h11,       3'd1};
    tbl[6]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 32'h22,       3'd0};
    tbl[7]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd7, 32'hFFFF, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'h22,     3'd0};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h22,       3'd0};
    tbl[9]  = '{1'b1, 3'd5, 32'h55,       1'b1, 3'd5, 32'h56, 3'd5, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h22,       3'd2};
    tbl[10] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd5, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 32'h55,       3'd1};
    tbl[11] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd5, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 32'h56,       3'd0};
    tbl[12] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd5, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 32'h56,       3'd0};

    // Reset with live requests: they must be discarded and ready held low.
    drive(1'b1, 1'b1, 3'd4, 32'h44, 1'b1, 3'd6, 32'h66, 3'd0, 3'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_src0_ready", 32'(src0_ready), 32'd0);
      chk("rst_src1_ready", 32'(src1_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd4, 3'd6);
    #1;
    chk("post_rst_pend1", 32'(q_pending1), 32'd0);
    chk("post_rst_pend2", 32'(q_pending2), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1'b0, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].q1, tbl[i].q2);
      #1;
      chk($sformatf("v%0d_src0_ready", i), 32'(src0_ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d_src1_ready", i), 32'(src1_ready), 32'(tbl[i].r1));
      chk($sformatf("v%0d_q_pending1", i), 32'(q_pending1), 32'(tbl[i].p1));
      chk($sformatf("v%0d_q_pending2", i), 32'(q_pending2), 32'(tbl[i].p2));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_rf_wa", i), 32'(rf_wa), 32'(tbl[i].wa));
      chk($sformatf("v%0d_rf_wd", i), rf_wd, tbl[i].wd);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
    end

    // Model-driven phases start from a reset so both sides agree.
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);

    // Both sources saturated across several pointer wraps.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 3'(i % 8), 32'h1000 + 32'(i), 1'b1, 3'((i + 3) % 8), 32'h2000 + 32'(i), 3'(i % 8), 3'(i % 7));
      chk("full_cnt_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
    end
    repeat (5) cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd1, 3'd2);

    // Reset mid-burst with three entries outstanding.
    cyc(1'b0, 1'b1, 3'd1, 32'hA1, 1'b1, 3'd2, 32'hA2, 3'd1, 3'd2);
    cyc(1'b0, 1'b1, 3'd3, 32'hA3, 1'b1, 3'd4, 32'hA4, 3'd3, 3'd4);
    chk("burst_count3", 32'(count), 32'd3);
    cyc(1'b1, 1'b1, 3'd5, 32'hA5, 1'b1, 3'd6, 32'hA6, 3'd3, 3'd4);
    chk("burst_rst_count", 32'(count), 32'd0);
    chk("burst_rst_we", 32'(rf_we), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd2, 3'd4);
      chk("burst_no_issue", 32'(rf_we), 32'd0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
